// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves conditional branches using the shared signed
// comparator, registers the decision and target, and holds flush for
// FLUSH_CYCLES cycles after a taken branch.
// Optional feature macro: BRANCH_UNSIGNED_EN (enables BLTU/BGEU through MSB inversion).
module branch_resolve_unit #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_cmp_a,
    output logic [XLEN-1:0] o_cmp_b,
    output logic [2:0]      o_cmp_oper,
    input  logic            i_cmp_val,
    output logic            o_res_valid,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_target,
    output logic            o_flush,
    output logic            o_illegal
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            r_res_valid;
    logic            r_redirect;
    logic            r_illegal;
    logic [XLEN-1:0] r_target;

    logic            w_legal;
    logic [2:0]      w_oper;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_accept;
    logic            w_taken;

    // Decode funct3 into a comparator operation; unsigned kinds bias both MSBs.
    always_comb begin
        w_legal = 1'b0;
        w_oper  = 3'b000;
        w_a     = i_rs1;
        w_b     = i_rs2;
        case (i_funct3)
            3'b000: begin w_legal = 1'b1; w_oper = 3'b000; end
            3'b001: begin w_legal = 1'b1; w_oper = 3'b001; end
            3'b100: begin w_legal = 1'b1; w_oper = 3'b010; end
            3'b101: begin w_legal = 1'b1; w_oper = 3'b101; end
`ifdef BRANCH_UNSIGNED_EN
            3'b110: begin
                w_legal = 1'b1;
                w_oper  = 3'b010;
                w_a     = {~i_rs1[XLEN-1], i_rs1[XLEN-2:0]};
                w_b     = {~i_rs2[XLEN-1], i_rs2[XLEN-2:0]};
            end
            3'b111: begin
                w_legal = 1'b1;
                w_oper  = 3'b101;
                w_a     = {~i_rs1[XLEN-1], i_rs1[XLEN-2:0]};
                w_b     = {~i_rs2[XLEN-1], i_rs2[XLEN-2:0]};
            end
`endif
            default: begin w_legal = 1'b0; w_oper = 3'b000; end
        endcase
    end

    assign w_accept = i_in_valid && (r_state == ST_IDLE);
    assign w_taken  = w_accept && w_legal && i_cmp_val;

    // Resolution state machine: registers result pulses, target and flush count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_res_valid <= 1'b0;
            r_redirect  <= 1'b0;
            r_illegal   <= 1'b0;
            r_target    <= '0;
        end else begin
            r_res_valid <= w_accept;
            r_redirect  <= w_taken;
            r_illegal   <= w_accept && !w_legal;
            if (w_taken) begin
                r_target <= i_pc + i_imm;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_taken) begin
                        r_state <= ST_FLUSH;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_in_ready  = (r_state == ST_IDLE);
    assign o_flush     = (r_state == ST_FLUSH);
    assign o_cmp_a     = w_a;
    assign o_cmp_b     = w_b;
    assign o_cmp_oper  = w_oper;
    assign o_res_valid = r_res_valid;
    assign o_redirect  = r_redirect;
    assign o_illegal   = r_illegal;
    assign o_target    = r_target;

endmodule
